led_pattern_player: RTL and testbench
=====================================

// Module: led_pattern_player
// PURPOSE
//   Programmable LED blink sequencer driving the board LED / user pins at 16 MHz.
//   Accepts a bit pattern plus length over a valid/ready handshake and plays it
//   LSB-first, one bit per prescaler period, to a registered LED output.
//   Double-buffered: the next pattern queues while the current one plays, so
//   patterns switch seamlessly. Sits directly upstream of the LED/PIN pad drive.
// PARAMETERS
//   TICK_DIV  2097152  CLK cycles per pattern bit (>=2; 2^21 = ~131 ms @16 MHz)
//   PAT_W     32       pattern width in bits (2..32)
//   PWM_W     4        brightness PWM counter width (LED_PWM_EN only)
// PORTS
//   CLK        in   1               system clock, 16 MHz
//   RST        in   1               synchronous reset, active-high
//   PAT_DATA   in   PAT_W           pattern bits; bit 0 plays first
//   PAT_LEN    in   6               bits to play, 1..PAT_W; 0 or >PAT_W means PAT_W
//   PAT_VALID  in   1               pattern offer
//   PAT_READY  out  1               shadow buffer empty; transfer on VALID&&READY
//   LOOP       in   1               1: repeat current pattern at its end
//   DUTY       in   PWM_W           brightness (present only with LED_PWM_EN)
//   LED_OUT    out  1               registered LED drive
//   BUSY       out  1               1 while in PLAY
//   DONE       out  1               one-cycle pulse when playback stops
// BEHAVIOUR
//   - One clock (CLK); RST is synchronous, active-high. While RST high and on the
//     first edge it is sampled: state IDLE, shadow empty, prescaler/index 0,
//     LED_OUT=0, BUSY=0, DONE=0, PAT_READY=0; PAT_READY=1 the cycle after RST falls.
//   - PAT_READY = !shadow_full, registered; no combinational path from PAT_VALID.
//   - Accept (VALID&&READY): PAT_DATA and clamped PAT_LEN stored in shadow.
//   - FSM IDLE: shadow full -> move shadow to active, index=0, prescaler=0,
//     shadow cleared, -> PLAY. Transfer edge = edge after accept (1 cycle).
//   - PLAY: LED_OUT <= active[index] each cycle (first bit visible the cycle
//     after transfer). Prescaler counts 0..TICK_DIV-1, wraps; on terminal count
//     index++. Each bit held exactly TICK_DIV cycles.
//   - Terminal count with index==len-1, priority order:
//     1) shadow full: load shadow into active, index=0, stay PLAY; no DONE, no gap.
//     2) LOOP==1 (sampled this cycle): index=0, stay PLAY.
//     3) else -> IDLE; DONE=1 for that cycle; LED_OUT=0, BUSY=0 same cycle.
//   - Accept and shadow->active transfer in same cycle: not possible (READY=0 when
//     full); new accept allowed the cycle after shadow clears.
//   - Prescaler width $clog2(TICK_DIV); index width $clog2(PAT_W); no overflow.
//   - PAT_LEN=1: single bit, TICK_DIV cycles. LOOP toggled mid-pattern: only the
//     value at last-bit terminal count matters.
//   - RST mid-playback: aborts immediately to reset values; queued pattern lost;
//     no DONE.
// CONFIGURATION
//   LED_PWM_EN defined: DUTY port present; free-running PWM_W-bit counter;
//     LED_OUT <= active[index] & (pwm_cnt < DUTY). DUTY=0 -> always off;
//     DUTY=2^PWM_W-1 -> on (2^PWM_W-1)/2^PWM_W of the time. pwm_cnt reset to 0.
//   LED_PWM_EN undefined: no DUTY port, no PWM counter; LED_OUT <= active[index].
// TESTING (TICK_DIV=4, PAT_W=32, PWM_W=4 for sim)
//   1. Hold RST 3 cycles -> LED_OUT/BUSY/DONE/PAT_READY=0; READY=1 cycle after RST low.
//   2. Offer 0b101, LEN=3, LOOP=0 at cycle 0 -> LED_OUT 1,0,1 each 4 cycles from
//      cycle 2; DONE pulse at cycle 14 with LED_OUT=0, BUSY=0.
//   3. 0b01, LEN=2, LOOP=1 -> LED_OUT square wave period 8 cycles, BUSY stays 1,
//      no DONE over 64 cycles; drop LOOP -> stops at next pattern end with DONE.
//   4. Play 0xF LEN=4, queue 0x0 LEN=4 mid-play -> READY low after accept; 16
//      cycles high then 16 low with no gap cycle and no DONE in between.
//   5. PAT_LEN=0 with 0x80000001 -> 32 bits played (128 cycles), high first/last 4.
//   6. RST at cycle 6 of play -> next cycle all outputs 0, no DONE; LED_PWM_EN with
//      pattern all-ones, DUTY=8 -> LED_OUT high exactly 8 of every 16 cycles.

Source files
------------

// File: rtl/led_pattern_player.sv
// LED blink sequencer: double-buffered pattern, played LSB-first, one bit per TICK_DIV clocks.
// Define LED_PWM_EN to add the DUTY port and a brightness PWM gate on LED_OUT.
module led_pattern_player #(
  parameter int TICK_DIV = 2097152,
  parameter int PAT_W    = 32
`ifdef LED_PWM_EN
  ,
  parameter int PWM_W    = 4
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PAT_W-1:0] PAT_DATA,
  input  logic [5:0]       PAT_LEN,
  input  logic             PAT_VALID,
  output logic             PAT_READY,
  input  logic             LOOP,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] DUTY,
`endif
  output logic             LED_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0]       LEN_MAX  = 6'(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_PLAY
  } state_t;

  state_t state_q, state_d;

  logic [PAT_W-1:0] shadow_data_q, shadow_data_d;
  logic [IDX_W-1:0] shadow_last_q, shadow_last_d;
  logic             shadow_full_q, shadow_full_d;
  logic [PAT_W-1:0] active_data_q, active_data_d;
  logic [IDX_W-1:0] active_last_q, active_last_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             tick;
  logic             last_bit;
  logic             accept;
  logic             pattern_end;
  logic             load_active;
  logic [IDX_W-1:0] len_last;
  logic             pwm_on;

  assign tick        = (presc_q == CNT_LAST);
  assign last_bit    = (index_q == active_last_q);
  assign accept      = PAT_VALID && ready_q;
  assign pattern_end = (state_q == ST_PLAY) && tick && last_bit;
  assign load_active = ((state_q == ST_IDLE) || pattern_end) && shadow_full_q;

  // Lengths are stored as the index of the last bit; 0 or oversize means full width.
  always_comb begin
    if ((PAT_LEN == 6'd0) || (PAT_LEN > LEN_MAX)) begin
      len_last = IDX_MAX;
    end else begin
      len_last = IDX_W'(PAT_LEN - 6'd1);
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;

  assign pwm_d  = pwm_q + 1'b1;
  assign pwm_on = (pwm_q < DUTY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a queued pattern always wins over looping or stopping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (shadow_full_q) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (pattern_end && !shadow_full_q && !LOOP) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer and bit-timing datapath
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_last_d = shadow_last_q;
    shadow_full_d = shadow_full_q;
    active_data_d = active_data_q;
    active_last_d = active_last_q;
    index_d       = index_q;
    presc_d       = presc_q;

    if (accept) begin
      shadow_data_d = PAT_DATA;
      shadow_last_d = len_last;
      shadow_full_d = 1'b1;
    end

    if (load_active) begin
      active_data_d = shadow_data_q;
      active_last_d = shadow_last_q;
      shadow_full_d = 1'b0;
      index_d       = '0;
      presc_d       = '0;
    end else if (state_q == ST_PLAY) begin
      if (tick) begin
        presc_d = '0;
        index_d = last_bit ? '0 : index_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Output logic: all outputs trail the FSM by one register so DONE, BUSY and
  // LED_OUT change on the same edge as the last bit finishes.
  always_comb begin
    led_d   = (state_q == ST_PLAY) && active_data_q[index_q] && pwm_on;
    busy_d  = (state_q == ST_PLAY);
    done_d  = (state_q == ST_IDLE) && busy_q;
    ready_d = !shadow_full_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_data_q <= '0;
      shadow_last_q <= '0;
      shadow_full_q <= 1'b0;
      active_data_q <= '0;
      active_last_q <= '0;
      index_q       <= '0;
      presc_q       <= '0;
      led_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_last_q <= shadow_last_d;
      shadow_full_q <= shadow_full_d;
      active_data_q <= active_data_d;
      active_last_q <= active_last_d;
      index_q       <= index_d;
      presc_q       <= presc_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
    end
  end

  assign PAT_READY = ready_q;
  assign LED_OUT   = led_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// Self-checking bench for led_pattern_player (TICK_DIV=4, PAT_W=32); vector table,
// hand-written corner sequences and random traffic against a timeline-based model.
module tb_led_pattern_player;
  localparam int TD = 4;
  localparam int PW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pat_data = '0;
  logic [5:0]  pat_len = '0;
  logic        pat_valid = 1'b0;
  logic        loop_i = 1'b0;
  wire         pat_ready;
  wire         led_out;
  wire         busy;
  wire         done;
`ifdef LED_PWM_EN
  logic [3:0]  duty = 4'd15;
`endif

  always #5 clk = ~clk;

  led_pattern_player #(
    .TICK_DIV(TD),
    .PAT_W   (PW)
`ifdef LED_PWM_EN
    ,
    .PWM_W   (4)
`endif
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .PAT_DATA (pat_data),
    .PAT_LEN  (pat_len),
    .PAT_VALID(pat_valid),
    .PAT_READY(pat_ready),
    .LOOP     (loop_i),
`ifdef LED_PWM_EN
    .DUTY     (duty),
`endif
    .LED_OUT  (led_out),
    .BUSY     (busy),
    .DONE     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: playback described as elapsed time within the current pattern.
  bit          m_play;
  logic [31:0] m_pat;
  int          m_len;
  int          m_el;
  bit          m_sh_full;
  logic [31:0] m_sh_pat;
  int          m_sh_len;
  bit          m_rdy;
  int          m_pwm;
  bit          e_led, e_busy, e_done, e_rdy;

  function automatic int clamp_len(input logic [5:0] l);
    if (l == 6'd0 || int'(l) > PW) return PW;
    return int'(l);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (rst) begin
      m_play = 0; m_pat = '0; m_len = 0; m_el = 0;
      m_sh_full = 0; m_sh_pat = '0; m_sh_len = 0; m_rdy = 0; m_pwm = 0;
      e_led = 0; e_busy = 0; e_done = 0; e_rdy = 0;
      return;
    end
    e_done = e_busy && !m_play;
    e_busy = m_play;
    e_led  = m_play ? m_pat[m_el / TD] : 1'b0;
`ifdef LED_PWM_EN
    e_led = e_led && (m_pwm < int'(duty));
    m_pwm = (m_pwm + 1) % 16;
`endif
    acc = pat_valid && m_rdy;
    if (m_play) begin
      if (m_el == m_len * TD - 1) begin
        if (m_sh_full) begin
          m_pat = m_sh_pat; m_len = m_sh_len; m_el = 0; m_sh_full = 0;
        end else if (loop_i) begin
          m_el = 0;
        end else begin
          m_play = 0;
        end
      end else begin
        m_el++;
      end
    end else if (m_sh_full) begin
      m_play = 1; m_pat = m_sh_pat; m_len = m_sh_len; m_el = 0; m_sh_full = 0;
    end
    if (acc) begin
      m_sh_pat = pat_data; m_sh_len = clamp_len(pat_len); m_sh_full = 1;
    end
    m_rdy = !m_sh_full;
    e_rdy = m_rdy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led_out", led_out, e_led);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("pat_ready", pat_ready, e_rdy);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; pat_valid = 1'b0; loop_i = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    step();
  endtask

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [5:0]  len;
    int          exp_busy;
    int          exp_high;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int busy_cnt, high_cnt, done_cnt, done_cyc;
    bit hist_led[64];
    bit hist_busy[64];
    bit hist_done[64];

    vecs[0] = '{"pat101_len3",  32'h0000_0005, 6'd3,  12,  8,  14};
    vecs[1] = '{"len0_full",    32'h8000_0001, 6'd0,  128, 8,  130};
    vecs[2] = '{"allon_len4",   32'h0000_000F, 6'd4,  16,  16, 18};
    vecs[3] = '{"len1_on",      32'h0000_0001, 6'd1,  4,   4,  6};
    vecs[4] = '{"len45_clamp",  32'hFFFF_FFFF, 6'd45, 128, 128, 130};
    vecs[5] = '{"aa_len8",      32'h0000_00AA, 6'd8,  32,  16, 34};
    vecs[6] = '{"len1_off",     32'hFFFF_FFFE, 6'd1,  4,   0,  6};
    vecs[7] = '{"len33_clamp",  32'h0000_0007, 6'd33, 128, 12, 130};

    // Reset behaviour: outputs low while held, READY rises the cycle after release
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready", pat_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_led", led_out, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    check("ready_after_rst", pat_ready, 1'b1);
    $display("reset sequence: ready=%b busy=%b", pat_ready, busy);

    // Table of single-pattern plays
    for (int v = 0; v < 8; v++) begin
      do_reset(3);
      pat_data = vecs[v].data; pat_len = vecs[v].len; pat_valid = 1'b1;
      step();
      pat_valid = 1'b0;
      busy_cnt = 0; high_cnt = 0; done_cyc = -1;
      for (int c = 1; c < 300 && done_cyc < 0; c++) begin
        step();
        if (busy) busy_cnt++;
        if (led_out) high_cnt++;
        if (done) done_cyc = c;
      end
      check_int({vecs[v].name, "_busy"}, busy_cnt, vecs[v].exp_busy);
`ifndef LED_PWM_EN
      check_int({vecs[v].name, "_high"}, high_cnt, vecs[v].exp_high);
`endif
      check_int({vecs[v].name, "_done_cycle"}, done_cyc, vecs[v].exp_done);
      $display("vector %s: busy=%0d high=%0d done_at=%0d", vecs[v].name, busy_cnt, high_cnt, done_cyc);
    end

    // Looping square wave, then stop after LOOP drops
    do_reset(3);
    loop_i = 1'b1; pat_data = 32'h1; pat_len = 6'd2; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    step();
    busy_cnt = 0; high_cnt = 0; done_cnt = 0;
    for (int c = 2; c < 66; c++) begin
      step();
      if (busy) busy_cnt++;
      if (led_out) high_cnt++;
      if (done) done_cnt++;
    end
    check_int("loop_busy", busy_cnt, 64);
`ifndef LED_PWM_EN
    check_int("loop_high", high_cnt, 32);
`endif
    check_int("loop_no_done", done_cnt, 0);
    loop_i = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 20 && done_cyc < 0; c++) begin
      step();
      if (done) done_cyc = c;
    end
    check_int("loop_stop_done", done_cyc, 8);
    $display("loop sequence: high=%0d busy=%0d done_after=%0d", high_cnt, busy_cnt, done_cyc);

    // Queued pattern switches seamlessly
    do_reset(3);
    for (int c = 0; c < 40; c++) begin
      pat_valid = (c == 0) || (c == 6);
      pat_data  = (c == 0) ? 32'hF : 32'h0;
      pat_len   = 6'd4;
      step();
      if (c == 6) check("ready_low_after_queue", pat_ready, 1'b0);
      hist_led[c] = led_out; hist_busy[c] = busy; hist_done[c] = done;
    end
    pat_valid = 1'b0;
    high_cnt = 0; busy_cnt = 0; done_cnt = 0;
    for (int c = 2; c < 18; c++) if (hist_led[c]) high_cnt++;
    for (int c = 18; c < 34; c++) if (!hist_led[c] && hist_busy[c]) busy_cnt++;
    for (int c = 0; c < 34; c++) if (hist_done[c]) done_cnt++;
`ifndef LED_PWM_EN
    check_int("queue_first_high", high_cnt, 16);
`endif
    check_int("queue_second_low_busy", busy_cnt, 16);
    check_int("queue_no_gap_done", done_cnt, 0);
    check("queue_final_done", hist_done[34], 1'b1);
    $display("queue sequence: high=%0d low_busy=%0d done34=%b", high_cnt, busy_cnt, hist_done[34]);

    // Reset during playback with a queued pattern
    do_reset(3);
    for (int c = 0; c < 8; c++) begin
      pat_valid = (c == 0) || (c == 3);
      pat_data  = 32'hFFFF_FFFF;
      pat_len   = 6'd0;
      step();
    end
    pat_valid = 1'b0;
    rst = 1'b1;
    step();
    check("abort_led", led_out, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ready", pat_ready, 1'b0);
    rst = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (12) begin
      step();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check_int("abort_queue_lost", busy_cnt, 0);
    check_int("abort_no_done", done_cnt, 0);
    $display("abort sequence: busy_after=%0d done_after=%0d", busy_cnt, done_cnt);

`ifdef LED_PWM_EN
    // Half brightness on an all-ones looping pattern
    do_reset(3);
    duty = 4'd8; loop_i = 1'b1;
    pat_data = 32'hFFFF_FFFF; pat_len = 6'd4; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    step();
    high_cnt = 0;
    repeat (32) begin
      step();
      if (led_out) high_cnt++;
    end
    check_int("pwm_half_duty", high_cnt, 16);
    $display("pwm sequence: high=%0d of 32", high_cnt);
    loop_i = 1'b0;
    duty = 4'd15;
`endif

    // Random traffic against the model
    do_reset(2);
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      pat_valid = ($urandom_range(0, 3) == 0);
      pat_data  = $urandom;
      pat_len   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 4));
      loop_i    = ($urandom_range(0, 5) == 0);
`ifdef LED_PWM_EN
      if ($urandom_range(0, 49) == 0) duty = 4'($urandom_range(0, 15));
`endif
      step();
    end
    rst = 1'b0; pat_valid = 1'b0;
    $display("random sequence: 4000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
